// File: rtl/tone_sched_pkg.sv
// Shared constants, FSM state type and source-priority helper for the tone scheduler.
package tone_sched_pkg;

    localparam logic [1:0] SRC_MATCH  = 2'd0;
    localparam logic [1:0] SRC_SPREAD = 2'd1;
    localparam logic [1:0] SRC_HALT   = 2'd2;
    localparam logic [1:0] SRC_NONE   = 2'd3;

    localparam int DEF_HP_MATCH    = 25000;
    localparam int DEF_HP_SPREAD   = 37500;
    localparam int DEF_HP_HALT     = 12500;
    localparam int DEF_TONE_CYCLES = 10000000;
    localparam int DEF_GAP_CYCLES  = 2500000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Fixed priority halt > spread > match over the nonzero-counter mask.
    function automatic logic [1:0] pick_src(input logic [2:0] nz);
        if (nz[2]) begin
            pick_src = SRC_HALT;
        end else if (nz[1]) begin
            pick_src = SRC_SPREAD;
        end else if (nz[0]) begin
            pick_src = SRC_MATCH;
        end else begin
            pick_src = SRC_NONE;
        end
    endfunction

endpackage

// File: rtl/pend_counter.sv
// Two-bit saturating pending-request counter; simultaneous inc and dec cancel out.
module pend_counter
    import tone_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] count,
    output logic       sat
);

    logic [1:0] count_r;

    // Counter update: saturate at 3, floor at 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= 2'd0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (count_r != 2'd3) begin
                        count_r <= count_r + 2'd1;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    if (count_r != 2'd0) begin
                        count_r <= count_r - 2'd1;
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign sat   = (count_r == 2'd3);

endmodule

// File: rtl/tone_scheduler.sv
// Queues match/spread/halt events and plays one prioritised tone at a time.
// Optional macro TONE_SCHED_PREEMPT_EN lets a pending halt interrupt a non-halt tone.
module tone_scheduler
    import tone_sched_pkg::*;
#(
    parameter int HP_MATCH    = DEF_HP_MATCH,
    parameter int HP_SPREAD   = DEF_HP_SPREAD,
    parameter int HP_HALT     = DEF_HP_HALT,
    parameter int TONE_CYCLES = DEF_TONE_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic        mute,
    output logic        tone_start,
    output logic [15:0] tone_half_period,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        overflow
);

    localparam logic [23:0] TONE_LAST = 24'(TONE_CYCLES - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);
    localparam bit          GAP_SKIP  = (GAP_CYCLES == 0);

    state_t      state_r;
    logic [23:0] timer_r;
    logic [1:0]  count_s [3];
    logic [2:0]  sat_s;
    logic [2:0]  dec_s;
    logic [2:0]  nz_s;
    logic [2:0]  drop_s;
    logic [1:0]  pick_s;
    logic [15:0] pick_hp_s;
    logic        launch_ok_s;
    logic        preempt_s;
    logic        launch_s;

    for (genvar i = 0; i < 3; i++) begin : g_pend
        pend_counter u_pend (
            .clk   (clk),
            .reset (reset),
            .inc   (req[i]),
            .dec   (dec_s[i]),
            .count (count_s[i]),
            .sat   (sat_s[i])
        );
        assign nz_s[i]  = (count_s[i] != 2'd0);
        assign dec_s[i] = (state_r == ST_START) && (grant_id == 2'(i));
    end

    assign drop_s      = req & sat_s & ~dec_s;
    assign pick_s      = pick_src(nz_s);
    assign launch_ok_s = (|nz_s) && !mute;

`ifdef TONE_SCHED_PREEMPT_EN
    assign preempt_s = nz_s[2] && !mute && (grant_id != SRC_HALT) &&
                       ((state_r == ST_PLAY) || (state_r == ST_GAP));
`else
    assign preempt_s = 1'b0;
`endif

    // Half-period lookup for the source about to be granted.
    always_comb begin
        pick_hp_s = 16'd0;
        case (pick_s)
            SRC_MATCH:  pick_hp_s = 16'(HP_MATCH);
            SRC_SPREAD: pick_hp_s = 16'(HP_SPREAD);
            SRC_HALT:   pick_hp_s = 16'(HP_HALT);
            default:    pick_hp_s = 16'd0;
        endcase
    end

    // A new tone starts from IDLE, or back-to-back at the end of GAP (or PLAY when there is no gap).
    always_comb begin
        launch_s = 1'b0;
        case (state_r)
            ST_IDLE:  launch_s = launch_ok_s;
            ST_PLAY:  launch_s = preempt_s || ((timer_r == 24'd0) && GAP_SKIP && launch_ok_s);
            ST_GAP:   launch_s = preempt_s || ((timer_r == 24'd0) && launch_ok_s);
            default:  launch_s = 1'b0;
        endcase
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r          <= ST_IDLE;
            timer_r          <= 24'd0;
            tone_start       <= 1'b0;
            tone_half_period <= 16'd0;
            grant_id         <= SRC_NONE;
            busy             <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            if (|drop_s) begin
                overflow <= 1'b1;
            end
            if (launch_s) begin
                state_r          <= ST_START;
                tone_start       <= 1'b1;
                busy             <= 1'b1;
                grant_id         <= pick_s;
                tone_half_period <= pick_hp_s;
            end else begin
                tone_start <= 1'b0;
                case (state_r)
                    ST_IDLE: begin
                        busy <= 1'b0;
                    end
                    ST_START: begin
                        state_r <= ST_PLAY;
                        timer_r <= TONE_LAST;
                    end
                    ST_PLAY: begin
                        if (timer_r != 24'd0) begin
                            timer_r <= timer_r - 24'd1;
                        end else if (GAP_SKIP) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= ST_GAP;
                            timer_r <= GAP_LAST;
                        end
                    end
                    ST_GAP: begin
                        if (timer_r != 24'd0) begin
                            timer_r <= timer_r - 24'd1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Randomised and directed bench for tone_scheduler against a tone-age reference model.
`timescale 1ns/1ps
module tb_tone_scheduler;

    localparam int T_CYC = 8;
    localparam int G_CYC = 4;
    localparam int LEN   = 1 + T_CYC + G_CYC;
    localparam int HP_M  = 25000;
    localparam int HP_S  = 37500;
    localparam int HP_H  = 12500;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req   = 3'b000;
    logic        mute  = 1'b0;
    logic        tone_start;
    logic [15:0] tone_half_period;
    logic [1:0]  grant_id;
    logic        busy;
    logic        overflow;

    tone_scheduler #(
        .HP_MATCH    (HP_M),
        .HP_SPREAD   (HP_S),
        .HP_HALT     (HP_H),
        .TONE_CYCLES (T_CYC),
        .GAP_CYCLES  (G_CYC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .mute             (mute),
        .tone_start       (tone_start),
        .tone_half_period (tone_half_period),
        .grant_id         (grant_id),
        .busy             (busy),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: pending counts plus the age of the tone currently sounding.
    int          m_pend [3] = '{0, 0, 0};
    bit          m_ovf   = 1'b0;
    bit          m_act   = 1'b0;
    int          m_age   = 0;
    logic [1:0]  m_gid   = 2'd3;
    logic [15:0] m_hp    = 16'd0;
    bit          m_start = 1'b0;

    function automatic logic [15:0] hp_of(int s);
        if (s == 2) return 16'(HP_H);
        if (s == 1) return 16'(HP_S);
        if (s == 0) return 16'(HP_M);
        return 16'd0;
    endfunction

    task automatic model_edge();
        int dec_src;
        int pick;
        bit go;
        if (!reset) begin
            m_pend = '{0, 0, 0};
            m_ovf = 1'b0; m_act = 1'b0; m_age = 0;
            m_gid = 2'd3; m_hp = 16'd0; m_start = 1'b0;
            return;
        end
        dec_src = (m_act && m_age == 0) ? int'(m_gid) : -1;
        pick = (m_pend[2] > 0) ? 2 : (m_pend[1] > 0) ? 1 : (m_pend[0] > 0) ? 0 : 3;
        go = 1'b0;
        if (!mute && pick != 3) begin
            if (!m_act) go = 1'b1;
            else if (m_age == LEN - 1) go = 1'b1;
`ifdef TONE_SCHED_PREEMPT_EN
            else if (m_age >= 1 && m_gid != 2'd2 && m_pend[2] > 0) go = 1'b1;
`endif
        end
        for (int i = 0; i < 3; i++) begin
            if (req[i] && i != dec_src) begin
                if (m_pend[i] == 3) m_ovf = 1'b1;
                else m_pend[i]++;
            end else if (!req[i] && i == dec_src) begin
                m_pend[i]--;
            end
        end
        m_start = go;
        if (go) begin
            m_act = 1'b1; m_age = 0; m_gid = 2'(pick); m_hp = hp_of(pick);
        end else if (m_act) begin
            if (m_age == LEN - 1) m_act = 1'b0;
            else m_age++;
        end
    endtask

    function automatic logic [20:0] dut_vec();
        return {tone_start, busy, grant_id, tone_half_period, overflow};
    endfunction

    function automatic logic [20:0] exp_vec();
        return {m_start, m_act, m_gid, m_hp, m_ovf};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic drain();
        bit done;
        req = 3'b000; mute = 1'b0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            done = !m_act && m_pend[0] == 0 && m_pend[1] == 0 && m_pend[2] == 0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout got=busy exp=idle");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 3'b000; mute = 1'b0;
        tick(); tick();
        checks++;
        if (dut_vec() !== {1'b0, 1'b0, 2'd3, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), {1'b0, 1'b0, 2'd3, 16'd0, 1'b0});
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_match();
        int lat = -1;
        int busy_n = 0;
        logic [1:0] gid = 2'd0;
        logic [15:0] hp = 16'd0;
        req = 3'b001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            req = 3'b000;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_match cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (tone_start && lat < 0) begin lat = i; gid = grant_id; hp = tone_half_period; end
            if (busy) busy_n++;
        end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", lat); end
        checks++;
        if (gid !== 2'd0 || hp !== 16'(HP_M)) begin
            errors++; $display("FAIL single_grant got=%0d/%0d exp=0/%0d", gid, hp, HP_M);
        end
        checks++;
        if (busy_n != LEN) begin errors++; $display("FAIL single_busy got=%0d exp=%0d", busy_n, LEN); end
    endtask

    task automatic test_all_three();
        int st[$];
        logic [1:0] gs[$];
        req = 3'b111;
        for (int i = 0; i < 60; i++) begin
            tick();
            req = 3'b000;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL all_three cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (tone_start) begin st.push_back(cyc); gs.push_back(grant_id); end
        end
        checks++;
        if (st.size() != 3) begin
            errors++; $display("FAIL all_three_count got=%0d exp=3", st.size());
        end else begin
            checks++;
            if (gs[0] !== 2'd2 || gs[1] !== 2'd1 || gs[2] !== 2'd0) begin
                errors++; $display("FAIL all_three_order got=%0d,%0d,%0d exp=2,1,0", gs[0], gs[1], gs[2]);
            end
            checks++;
            if (st[1] - st[0] != LEN || st[2] - st[1] != LEN) begin
                errors++; $display("FAIL all_three_spacing got=%0d,%0d exp=%0d", st[1] - st[0], st[2] - st[1], LEN);
            end
        end
    endtask

    task automatic test_overflow();
        int starts = 0;
        req = 3'b001;
        for (int i = 0; i < 80; i++) begin
            tick();
            req = (i >= 2 && i < 7) ? 3'b001 : 3'b000;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (tone_start && i >= 3) starts++;
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got=%b exp=1", overflow); end
        checks++;
        if (starts != 3) begin errors++; $display("FAIL overflow_tones got=%0d exp=3", starts); end
    endtask

    task automatic test_mute();
        int muted_starts = 0;
        int starts = 0;
        mute = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req = (i == 2 || i == 6) ? 3'b010 : 3'b000;
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mute cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (tone_start) muted_starts++;
        end
        req = 3'b000; mute = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL unmute cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (tone_start && grant_id === 2'd1) starts++;
        end
        checks++;
        if (muted_starts != 0) begin errors++; $display("FAIL mute_quiet got=%0d exp=0", muted_starts); end
        checks++;
        if (starts != 2) begin errors++; $display("FAIL mute_release got=%0d exp=2", starts); end
    endtask

    task automatic test_reset_mid();
        int starts = 0;
        req = 3'b001;
        tick();
        req = 3'b000;
        repeat (3) tick();
        req = 3'b011;
        tick();
        req = 3'b000;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (dut_vec() !== {1'b0, 1'b0, 2'd3, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", dut_vec(), {1'b0, 1'b0, 2'd3, 16'd0, 1'b0});
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_idle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (tone_start) starts++;
        end
        checks++;
        if (starts != 0) begin errors++; $display("FAIL reset_mid_quiet got=%0d exp=0", starts); end
    endtask

    task automatic test_preempt();
        int ms = -1;
        int hs = -1;
        int rc = 0;
        req = 3'b001;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 3) rc = cyc;
            req = (i == 2) ? 3'b100 : 3'b000;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL preempt cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (tone_start && grant_id === 2'd0 && ms < 0) ms = cyc;
            if (tone_start && grant_id === 2'd2 && hs < 0) hs = cyc;
        end
`ifdef TONE_SCHED_PREEMPT_EN
        checks++;
        if (hs - rc != 1) begin errors++; $display("FAIL preempt_latency got=%0d exp=1", hs - rc); end
`else
        checks++;
        if (hs - ms != LEN) begin errors++; $display("FAIL no_preempt_wait got=%0d exp=%0d", hs - ms, LEN); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            req   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            if ($urandom_range(0, 29) == 0) mute = ~mute;
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_match();
        drain();
        test_all_three();
        drain();
        test_overflow();
        drain();
        test_mute();
        drain();
        test_reset_mid();
        drain();
        test_preempt();
        drain();
        test_random();
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
